// File: rtl/riscv_csr_pkg.sv
// Machine-mode CSR addresses, rd source encodings, trap cause codes and
// status/enable bit positions shared by the writeback stage and its CSR file.
package riscv_csr_pkg;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

    localparam logic [1:0] WSEL_ALU  = 2'b00;
    localparam logic [1:0] WSEL_CSR  = 2'b01;
    localparam logic [1:0] WSEL_LOAD = 2'b10;
    localparam logic [1:0] WSEL_PC4  = 2'b11;

    localparam logic [3:0] EXC_INSN_MISALIGN  = 4'd0;
    localparam logic [3:0] EXC_LOAD_MISALIGN  = 4'd4;
    localparam logic [3:0] EXC_STORE_MISALIGN = 4'd6;

    localparam logic [3:0] IRQ_MSI = 4'd3;
    localparam logic [3:0] IRQ_MTI = 4'd7;
    localparam logic [3:0] IRQ_MEI = 4'd11;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;
    localparam int MIE_MSIE     = 3;
    localparam int MIE_MTIE     = 7;
    localparam int MIE_MEIE     = 11;

    typedef struct packed {
        logic        en;
        logic [31:0] cause;
        logic [31:0] epc;
        logic [31:0] tval;
    } trap_req_t;

    // Misaligned-address causes report the faulting address in mtval.
    function automatic logic tval_kept(input logic [3:0] ecause);
        return (ecause == EXC_INSN_MISALIGN) || (ecause == EXC_LOAD_MISALIGN) ||
               (ecause == EXC_STORE_MISALIGN);
    endfunction

endpackage

// File: rtl/csr_file.sv
// Machine trap CSRs and 64-bit cycle/instret counters, with the combinational
// read mux and the trap/mret side effects on mstatus, mepc, mcause and mtval.
module csr_file
    import riscv_csr_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] read_address,
    output logic [31:0] read_data,
    input  logic        write_en,
    input  logic [11:0] write_address,
    input  logic [31:0] write_data,
    input  trap_req_t   trap,
    input  logic        mret,
    input  logic        retire,
    input  logic [31:0] mip,
    output logic [31:0] trap_vector,
    output logic [31:0] mepc,
    output logic [31:0] mie,
    output logic        mstatus_mie
);
    localparam logic [31:0] MIE_MASK = 32'h0000_0888;

    logic        mpie;
    logic [31:0] mtvec, mscratch, mcause, mtval;
    logic [63:0] mcycle, minstret;
    logic [31:0] mstatus;

    always_comb begin
        mstatus               = '0;
        mstatus[MSTATUS_MIE]  = mstatus_mie;
        mstatus[MSTATUS_MPIE] = mpie;
    end

    assign trap_vector = {mtvec[31:2], 2'b00};

    always_comb begin
        case (read_address)
            CSR_MSTATUS:   read_data = mstatus;
            CSR_MIE:       read_data = mie;
            CSR_MTVEC:     read_data = mtvec;
            CSR_MSCRATCH:  read_data = mscratch;
            CSR_MEPC:      read_data = mepc;
            CSR_MCAUSE:    read_data = mcause;
            CSR_MTVAL:     read_data = mtval;
            CSR_MIP:       read_data = mip;
            CSR_MCYCLE:    read_data = mcycle[31:0];
            CSR_MCYCLEH:   read_data = mcycle[63:32];
            CSR_MINSTRET:  read_data = minstret[31:0];
            CSR_MINSTRETH: read_data = minstret[63:32];
            default:       read_data = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mstatus_mie <= 1'b0;
            mpie        <= 1'b0;
            mie         <= '0;
            mtvec       <= '0;
            mscratch    <= '0;
            mepc        <= '0;
            mcause      <= '0;
            mtval       <= '0;
            mcycle      <= '0;
            minstret    <= '0;
        end else begin
            mcycle <= mcycle + 64'd1;
            if (retire)
                minstret <= minstret + 64'd1;
            // Later assignments win, so a counter-half write replaces the increment.
            if (write_en) begin
                case (write_address)
                    CSR_MSTATUS: begin
                        mstatus_mie <= write_data[MSTATUS_MIE];
                        mpie        <= write_data[MSTATUS_MPIE];
                    end
                    CSR_MIE:       mie      <= write_data & MIE_MASK;
                    CSR_MTVEC:     mtvec    <= write_data;
                    CSR_MSCRATCH:  mscratch <= write_data;
                    CSR_MEPC:      mepc     <= {write_data[31:2], 2'b00};
                    CSR_MCAUSE:    mcause   <= write_data;
                    CSR_MTVAL:     mtval    <= write_data;
                    CSR_MCYCLE:    mcycle   <= {mcycle[63:32], write_data};
                    CSR_MCYCLEH:   mcycle   <= {write_data, mcycle[31:0]};
                    CSR_MINSTRET:  minstret <= {minstret[63:32], write_data};
                    CSR_MINSTRETH: minstret <= {write_data, minstret[31:0]};
                    default: ;
                endcase
            end
            if (trap.en) begin
                mepc        <= {trap.epc[31:2], 2'b00};
                mcause      <= trap.cause;
                mtval       <= trap.tval;
                mpie        <= mstatus_mie;
                mstatus_mie <= 1'b0;
            end else if (mret) begin
                mstatus_mie <= mpie;
                mpie        <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/writeback.sv
// Writeback stage: register-file commit, interrupt arbitration, exception/mret
// redirect and the wfi RUN/WAIT sequencer in front of the CSR file.
module writeback
    import riscv_csr_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_in,
    input  logic [31:0] next_pc_in,
    input  logic [31:0] alu_data_in,
    input  logic [31:0] csr_data_in,
    input  logic [31:0] load_data_in,
    input  logic [1:0]  write_select_in,
    input  logic [4:0]  rd_address_in,
    input  logic [11:0] csr_address_in,
    input  logic        csr_write_in,
    input  logic        mret_in,
    input  logic        wfi_in,
    input  logic        valid_in,
    input  logic        exception_in,
    input  logic [3:0]  ecause_in,
    input  logic        meip,
    input  logic        mtip,
    input  logic        msip,
    input  logic [11:0] csr_read_address,
    output logic [31:0] csr_read_data,
    output logic        reg_write,
    output logic [4:0]  reg_address,
    output logic [31:0] reg_data,
    output logic        trap_taken,
    output logic [31:0] trap_address,
    output logic        wfi_stall,
    output logic        retired
);
    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    logic [0:0]  state;
    logic [31:0] wfi_next_pc;
    logic [31:0] mip, mie, pend, mepc, trap_vector;
    logic        mstatus_mie, in_run, in_wait;
    logic        irq_take, exc_take, commit, mret_commit;
    logic [3:0]  irq_code;
    trap_req_t   trap;

    always_comb begin
        mip           = '0;
        mip[MIE_MEIE] = meip;
        mip[MIE_MTIE] = mtip;
        mip[MIE_MSIE] = msip;
    end
    assign pend = mip & mie;

    // Outputs are forced quiet while reset is high by qualifying both states.
    assign in_run  = !reset && (state == ST_RUN);
    assign in_wait = !reset && (state == ST_WAIT);

    assign irq_take    = mstatus_mie && (|pend) && ((in_run && valid_in) || in_wait);
    assign exc_take    = in_run && valid_in && exception_in && !irq_take;
    assign commit      = in_run && valid_in && !exception_in && !irq_take;
    assign mret_commit = commit && mret_in;

    always_comb begin
        if (pend[MIE_MEIE])      irq_code = IRQ_MEI;
        else if (pend[MIE_MSIE]) irq_code = IRQ_MSI;
        else                     irq_code = IRQ_MTI;
    end

    always_comb begin
        trap.en    = irq_take || exc_take;
        trap.cause = irq_take ? {1'b1, 27'b0, irq_code} : {28'b0, ecause_in};
        // Waking from wfi resumes after the wfi, which has already retired.
        trap.epc   = (irq_take && in_wait) ? wfi_next_pc : pc_in;
        trap.tval  = (exc_take && tval_kept(ecause_in)) ? alu_data_in : 32'b0;
    end

    always_comb begin
        case (write_select_in)
            WSEL_ALU:  reg_data = alu_data_in;
            WSEL_CSR:  reg_data = csr_data_in;
            WSEL_LOAD: reg_data = load_data_in;
            default:   reg_data = next_pc_in;
        endcase
    end

    assign reg_write    = commit && (rd_address_in != 5'd0);
    assign reg_address  = rd_address_in;
    assign retired      = commit;
    assign wfi_stall    = in_wait;
    assign trap_taken   = trap.en || mret_commit;
    assign trap_address = mret_commit ? mepc : trap_vector;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_RUN;
            wfi_next_pc <= '0;
        end else begin
            case (state)
                ST_RUN: if (commit && wfi_in) begin
                    state       <= ST_WAIT;
                    wfi_next_pc <= next_pc_in;
                end
                default: if (|pend) state <= ST_RUN;
            endcase
        end
    end

    csr_file u_csr (
        .clk           (clk),
        .reset         (reset),
        .read_address  (csr_read_address),
        .read_data     (csr_read_data),
        .write_en      (commit && csr_write_in),
        .write_address (csr_address_in),
        .write_data    (alu_data_in),
        .trap          (trap),
        .mret          (mret_commit),
        .retire        (commit),
        .mip           (mip),
        .trap_vector   (trap_vector),
        .mepc          (mepc),
        .mie           (mie),
        .mstatus_mie   (mstatus_mie)
    );

endmodule

// File: tb/tb_writeback.sv
// Scoreboard bench for writeback: expectations are queued as stimulus is set up
// and drained against the combinational outputs and the CSR read port.
module tb_writeback;
    import riscv_csr_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_in, next_pc_in, alu_data_in, csr_data_in, load_data_in;
    logic [1:0]  write_select_in;
    logic [4:0]  rd_address_in;
    logic [11:0] csr_address_in, csr_read_address;
    logic        csr_write_in, mret_in, wfi_in, valid_in, exception_in;
    logic [3:0]  ecause_in;
    logic        meip, mtip, msip;
    logic [31:0] csr_read_data, reg_data, trap_address;
    logic [4:0]  reg_address;
    logic        reg_write, trap_taken, wfi_stall, retired;

    writeback dut (
        .clk(clk), .reset(reset), .pc_in(pc_in), .next_pc_in(next_pc_in),
        .alu_data_in(alu_data_in), .csr_data_in(csr_data_in), .load_data_in(load_data_in),
        .write_select_in(write_select_in), .rd_address_in(rd_address_in),
        .csr_address_in(csr_address_in), .csr_write_in(csr_write_in), .mret_in(mret_in),
        .wfi_in(wfi_in), .valid_in(valid_in), .exception_in(exception_in),
        .ecause_in(ecause_in), .meip(meip), .mtip(mtip), .msip(msip),
        .csr_read_address(csr_read_address), .csr_read_data(csr_read_data),
        .reg_write(reg_write), .reg_address(reg_address), .reg_data(reg_data),
        .trap_taken(trap_taken), .trap_address(trap_address),
        .wfi_stall(wfi_stall), .retired(retired)
    );

    always #50 clk = ~clk;

    localparam int S_RW = 0, S_RD = 1, S_TT = 2, S_TA = 3, S_WS = 4, S_RT = 5, S_CSR = 6;

    typedef struct {
        string       tag;
        int          sel;
        logic [11:0] addr;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input int sel, input logic [11:0] addr,
                        input logic [31:0] val);
        exp_t e;
        e.tag = tag; e.sel = sel; e.addr = addr; e.val = val;
        sb.push_back(e);
    endtask

    task automatic e_sig(input string tag, input int sel, input logic [31:0] val);
        push(tag, sel, 12'h000, val);
    endtask

    task automatic e_csr(input string tag, input logic [11:0] addr, input logic [31:0] val);
        push(tag, S_CSR, addr, val);
    endtask

    task automatic drain();
        exp_t        e;
        logic [31:0] obs;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            csr_read_address = e.addr;
            #1;
            case (e.sel)
                S_RW:    obs = {31'b0, reg_write};
                S_RD:    obs = reg_data;
                S_TT:    obs = {31'b0, trap_taken};
                S_TA:    obs = trap_address;
                S_WS:    obs = {31'b0, wfi_stall};
                S_RT:    obs = {31'b0, retired};
                default: obs = csr_read_data;
            endcase
            chk(e.tag, obs, e.val);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        pc_in = '0; next_pc_in = '0; alu_data_in = '0; csr_data_in = '0;
        load_data_in = '0; write_select_in = WSEL_ALU; rd_address_in = '0;
        csr_address_in = '0; csr_write_in = 0; mret_in = 0; wfi_in = 0;
        valid_in = 0; exception_in = 0; ecause_in = '0;
    endtask

    task automatic csr_wr(input logic [11:0] addr, input logic [31:0] val);
        idle();
        valid_in = 1; csr_write_in = 1; csr_address_in = addr; alu_data_in = val;
        tick();
        idle();
    endtask

    task automatic issue_wfi(input logic [31:0] pc);
        idle();
        valid_in = 1; wfi_in = 1; pc_in = pc; next_pc_in = pc + 32'd4;
        e_sig("wfi_retired", S_RT, 1);
        e_sig("wfi_no_stall_yet", S_WS, 0);
        drain();
        tick();
        idle();
    endtask

    initial begin
        idle();
        meip = 0; mtip = 0; msip = 0; csr_read_address = '0;
        reset = 1;
        valid_in = 1; rd_address_in = 5'd5; alu_data_in = 32'h1234; wfi_in = 1;
        tick(); tick();
        e_sig("rst_reg_write", S_RW, 0);
        e_sig("rst_retired", S_RT, 0);
        e_sig("rst_trap", S_TT, 0);
        e_sig("rst_stall", S_WS, 0);
        drain();
        idle();
        reset = 0;
        e_csr("rst_mstatus", CSR_MSTATUS, 0);
        e_csr("rst_mtvec", CSR_MTVEC, 0);
        e_csr("rst_mcycle", CSR_MCYCLE, 0);
        e_csr("rst_minstret", CSR_MINSTRET, 0);
        drain();

        // plain ALU commits
        valid_in = 1; rd_address_in = 5'd5; alu_data_in = 32'h1234;
        e_sig("alu_we", S_RW, 1); e_sig("alu_data", S_RD, 32'h1234); e_sig("alu_ret", S_RT, 1);
        drain(); tick();
        rd_address_in = 5'd0;
        e_sig("rd0_we", S_RW, 0); e_sig("rd0_ret", S_RT, 1);
        drain(); tick();
        idle();
        e_csr("minstret_2", CSR_MINSTRET, 2);
        drain();
        valid_in = 1; rd_address_in = 5'd9; write_select_in = WSEL_LOAD; load_data_in = 32'hCAFE_0001;
        e_sig("load_data", S_RD, 32'hCAFE_0001); drain();
        write_select_in = WSEL_PC4; next_pc_in = 32'h0000_0104;
        e_sig("pc4_data", S_RD, 32'h104); drain();
        idle();

        // mtvec write; old CSR value goes to rd
        valid_in = 1; csr_write_in = 1; csr_address_in = CSR_MTVEC; alu_data_in = 32'h80;
        write_select_in = WSEL_CSR; csr_data_in = 32'hDEAD; rd_address_in = 5'd3;
        e_sig("csr_rd_data", S_RD, 32'hDEAD); e_sig("csr_rd_we", S_RW, 1);
        drain(); tick(); idle();
        e_csr("mtvec", CSR_MTVEC, 32'h80); drain();

        // misaligned load, with a suppressed mscratch write
        valid_in = 1; exception_in = 1; ecause_in = 4'd4; pc_in = 32'h100; alu_data_in = 32'h203;
        rd_address_in = 5'd7; write_select_in = WSEL_LOAD; csr_write_in = 1; csr_address_in = CSR_MSCRATCH;
        e_sig("exc_trap", S_TT, 1); e_sig("exc_addr", S_TA, 32'h80);
        e_sig("exc_we", S_RW, 0); e_sig("exc_ret", S_RT, 0);
        drain(); tick(); idle();
        e_csr("exc_mepc", CSR_MEPC, 32'h100); e_csr("exc_mcause", CSR_MCAUSE, 4);
        e_csr("exc_mtval", CSR_MTVAL, 32'h203); e_csr("exc_mstatus", CSR_MSTATUS, 0);
        e_csr("exc_mscratch", CSR_MSCRATCH, 0);
        drain();
        valid_in = 1; exception_in = 1; ecause_in = 4'd2; pc_in = 32'h104; alu_data_in = 32'h55;
        tick(); idle();
        e_csr("ill_mtval", CSR_MTVAL, 0); e_csr("ill_mcause", CSR_MCAUSE, 2); drain();

        // mie and an unlisted address
        csr_wr(CSR_MIE, 32'h888);
        e_csr("mie", CSR_MIE, 32'h888); drain();
        csr_wr(12'h7C0, 32'h1234_5678);
        e_csr("unlisted", 12'h7C0, 0); drain();
        csr_wr(CSR_MSTATUS, 32'hFFFF_FFFF);
        e_csr("mstatus_mask", CSR_MSTATUS, 32'h88); drain();

        // timer interrupt on a valid instruction
        mtip = 1;
        e_sig("irq_no_insn", S_TT, 0); e_csr("mip", CSR_MIP, 32'h80); drain();
        valid_in = 1; pc_in = 32'h40; rd_address_in = 5'd5; alu_data_in = 32'h77;
        e_sig("irq_trap", S_TT, 1); e_sig("irq_addr", S_TA, 32'h80);
        e_sig("irq_we", S_RW, 0); e_sig("irq_ret", S_RT, 0);
        drain(); tick(); idle(); mtip = 0;
        e_csr("irq_mcause", CSR_MCAUSE, 32'h8000_0007); e_csr("irq_mepc", CSR_MEPC, 32'h40);
        e_csr("irq_mstatus", CSR_MSTATUS, 32'h80);
        drain();

        // priority: external over software over timer; interrupt beats exception
        csr_wr(CSR_MSTATUS, 32'h8);
        meip = 1; msip = 1; mtip = 1;
        valid_in = 1; pc_in = 32'h44;
        tick(); idle(); meip = 0; msip = 0; mtip = 0;
        e_csr("prio_mei", CSR_MCAUSE, 32'h8000_000B); e_csr("prio_mepc", CSR_MEPC, 32'h44); drain();
        csr_wr(CSR_MSTATUS, 32'h8);
        msip = 1; mtip = 1;
        valid_in = 1; exception_in = 1; ecause_in = 4'd4; pc_in = 32'h48; alu_data_in = 32'h999;
        tick(); idle(); msip = 0; mtip = 0;
        e_csr("prio_msi", CSR_MCAUSE, 32'h8000_0003); e_csr("irq_exc_mepc", CSR_MEPC, 32'h48);
        e_csr("irq_exc_mtval", CSR_MTVAL, 0);
        drain();

        // wfi wake without trap (MIE=0)
        issue_wfi(32'h20);
        e_sig("wait_stall", S_WS, 1); e_sig("wait_no_trap", S_TT, 0); drain();
        tick();
        e_sig("wait_stall2", S_WS, 1); drain();
        meip = 1;
        e_sig("wake_no_trap", S_TT, 0); e_sig("wake_stall", S_WS, 1); e_sig("wake_ret", S_RT, 0);
        drain(); tick(); meip = 0;
        e_sig("resumed", S_WS, 0); e_csr("wake_mcause", CSR_MCAUSE, 32'h8000_0003); drain();

        // wfi wake with trap (MIE=1)
        csr_wr(CSR_MSTATUS, 32'h8);
        issue_wfi(32'h20);
        e_sig("wait2_stall", S_WS, 1); drain();
        meip = 1;
        e_sig("wfi_irq_trap", S_TT, 1); e_sig("wfi_irq_addr", S_TA, 32'h80);
        drain(); tick(); meip = 0;
        e_csr("wfi_mcause", CSR_MCAUSE, 32'h8000_000B); e_csr("wfi_mepc", CSR_MEPC, 32'h24);
        e_sig("wfi_resumed", S_WS, 0);
        drain();

        // exception beats mret, then a real mret
        csr_wr(CSR_MEPC, 32'h303);
        e_csr("mepc_align", CSR_MEPC, 32'h300); drain();
        csr_wr(CSR_MSTATUS, 32'h80);
        valid_in = 1; exception_in = 1; ecause_in = 4'd2; mret_in = 1; pc_in = 32'h60;
        e_sig("exc_mret_addr", S_TA, 32'h80); e_sig("exc_mret_ret", S_RT, 0);
        drain(); tick(); idle();
        e_csr("exc_mret_mepc", CSR_MEPC, 32'h60); e_csr("exc_mret_mstatus", CSR_MSTATUS, 0); drain();
        csr_wr(CSR_MEPC, 32'h300);
        csr_wr(CSR_MSTATUS, 32'h80);
        valid_in = 1; mret_in = 1; pc_in = 32'h70;
        e_sig("mret_trap", S_TT, 1); e_sig("mret_addr", S_TA, 32'h300); e_sig("mret_ret", S_RT, 1);
        drain(); tick(); idle();
        e_csr("mret_mstatus", CSR_MSTATUS, 32'h88); drain();

        // counters: write precedence and 64-bit wrap
        csr_wr(CSR_MCYCLEH, 32'hFFFF_FFFF);
        csr_wr(CSR_MCYCLE, 32'hFFFF_FFFF);
        e_csr("mcycle_wr_lo", CSR_MCYCLE, 32'hFFFF_FFFF); e_csr("mcycle_wr_hi", CSR_MCYCLEH, 32'hFFFF_FFFF);
        drain(); tick();
        e_csr("mcycle_wrap_lo", CSR_MCYCLE, 0); e_csr("mcycle_wrap_hi", CSR_MCYCLEH, 0); drain();
        csr_wr(CSR_MINSTRET, 32'h10);
        e_csr("minstret_wr", CSR_MINSTRET, 32'h10); drain();
        tick();
        e_csr("minstret_idle", CSR_MINSTRET, 32'h10); drain();
        valid_in = 1; tick(); idle();
        e_csr("minstret_inc", CSR_MINSTRET, 32'h11); drain();

        // reset while waiting
        issue_wfi(32'h80);
        e_sig("pre_rst_stall", S_WS, 1); drain();
        reset = 1;
        e_sig("rst_wait_stall", S_WS, 0); drain();
        tick(); tick();
        reset = 0;
        e_sig("post_rst_stall", S_WS, 0);
        e_csr("post_rst_mstatus", CSR_MSTATUS, 0); e_csr("post_rst_mie", CSR_MIE, 0);
        e_csr("post_rst_mtvec", CSR_MTVEC, 0); e_csr("post_rst_mepc", CSR_MEPC, 0);
        e_csr("post_rst_mcause", CSR_MCAUSE, 0); e_csr("post_rst_minstret", CSR_MINSTRET, 0);
        drain();
        tick();
        e_sig("post_rst_run", S_WS, 0); drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/writeback.md
# writeback

Final stage of the five-stage pipeline: consumes the registered outputs of the memory stage, commits results to the register file, owns the machine-mode trap CSRs and retirement counters, and sequences exceptions, interrupts, `mret` and `wfi`. It redirects fetch on traps and holds the pipeline while waiting for an interrupt.

## Interface
- Parameters: none.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `pc_in`, `next_pc_in` in 32: retiring instruction PC and its sequential successor.
- `alu_data_in` in 32: ALU result. It is also the new CSR value and the faulting address.
- `csr_data_in` in 32: old CSR value, read in execute.
- `load_data_in` in 32: load result, already sized and extended by busio.
- `write_select_in` in 2: rd source. 00 alu, 01 csr_data, 10 load_data, 11 next_pc.
- `rd_address_in` in 5, `csr_address_in` in 12, `csr_write_in` in 1, `mret_in` in 1, `wfi_in` in 1.
- `valid_in` in 1, `exception_in` in 1, `ecause_in` in 4.
- `meip`, `mtip`, `msip` in 1 each: level interrupt requests.
- `csr_read_address` in 12 / `csr_read_data` out 32: combinational read port for execute.
- `reg_write` out 1, `reg_address` out 5, `reg_data` out 32: register file write port.
- `trap_taken` out 1, `trap_address` out 32: fetch redirect; the hazard unit also uses it to invalidate.
- `wfi_stall` out 1: to hazard, freezes all earlier stages.
- `retired` out 1: an instruction committed this cycle.

## Operation
- Commit condition: `valid_in && !exception_in && !irq_take`.
  - On commit: `reg_write = (rd_address_in != 0)`, with data chosen by `write_select_in`.
  - If `csr_write_in`, the CSR at `csr_address_in` receives `alu_data_in` at the clock edge.
  - Register and CSR writes are suppressed on exception or interrupt.
- Interrupt pending set `pend = {meip&MEIE, msip&MSIE, mtip&MTIE}`.
  - `irq_take = mstatus.MIE && |pend && (valid_in || state==WAIT)`.
  - Priority: external (cause 11), then software (3), then timer (7). mcause bit 31 is set.
- Exception (`valid_in && exception_in`):
  - mepc ← pc_in; mcause ← {28'b0, ecause_in}.
  - mtval ← alu_data_in for causes 0, 4, 6; otherwise 0.
- Any trap:
  - MPIE ← MIE, MIE ← 0.
  - `trap_taken` = 1, `trap_address = {mtvec[31:2], 2'b00}`. Only direct mode is supported.
  - For an interrupt on a valid instruction, mepc ← pc_in and the instruction does not commit.
- `mret` commit: MIE ← MPIE, MPIE ← 1, `trap_taken` = 1, `trap_address` = mepc.
- FSM with states RUN and WAIT:
  - RUN → WAIT when a `wfi` commits; the `wfi` itself retires.
  - In WAIT, `wfi_stall` = 1.
  - WAIT → RUN when `|(mip & mie)`, regardless of mstatus.MIE.
  - If `irq_take` fires in that same cycle, mepc ← saved next_pc of the `wfi` and the trap is taken.
- CSRs:
  - 0x300 mstatus: only MIE (bit 3) and MPIE (bit 7) are implemented; other bits read 0.
  - 0x304 mie: bits 3, 7, 11.
  - 0x305 mtvec, 0x340 mscratch, 0x341 mepc (bits [1:0] forced 0), 0x342 mcause, 0x343 mtval.
  - 0x344 mip: read-only, built from the inputs.
  - 0xB00/0xB80 mcycle, 0xB02/0xB82 minstret: 64-bit.
  - Unlisted addresses read 0 and ignore writes.
- Counters:
  - mcycle increments every cycle.
  - minstret increments on `retired`.
  - A CSR write to a counter half takes precedence over that cycle's increment.
  - Wrap-around is modulo 2^64.

## Timing
- `reg_*`, `trap_*`, `retired`, `wfi_stall` and `csr_read_data` are combinational from the inputs and state. All state updates at `posedge clk`.
- A CSR written by a committing instruction is visible on `csr_read_data` the next cycle. The hazard unit stalls execute on CSR RAW.
- A trap or `mret` takes zero cycles in this stage; fetch redirects on the following edge.
- Reset:
  - All CSRs and counters are 0; state is RUN.
  - `reg_write`, `trap_taken`, `retired` and `wfi_stall` are 0 while `reset` is high.
  - A reset during WAIT returns the FSM to RUN.
- Exception and `mret` on the same instruction: the exception wins.
- Interrupt and exception on the same instruction: the interrupt wins, and mepc ← pc_in.

## Structure
- Package `riscv_csr_pkg`:
  - CSR address constants.
  - write_select encodings.
  - Exception and interrupt cause codes.
  - mstatus and mie bit indices.
- Sub-module `csr_file`:
  - Holds the CSR registers and counters.
  - Provides the read mux and the trap/mret update logic.
- `writeback` contains the commit logic, interrupt arbitration and the WAIT FSM.

## Test plan
- ALU commit: write_select=00, rd=5, alu=0x1234 → reg_write=1, reg_data=0x1234. Repeat with rd=0 → reg_write=0.
- Misaligned load: exception_in=1, ecause=4, pc=0x100, alu=0x203, mtvec=0x80 → trap_address=0x80; then mepc=0x100, mcause=4, mtval=0x203, MIE=0, no reg_write.
- CSR write: mie=0x888 via csr_write_in → read of 0x304 returns 0x888 the next cycle; csr_data_in goes to rd.
- Interrupt: MIE=1, MTIE=1, mtip=1, valid pc=0x40 → trap taken, mcause=0x80000007, mepc=0x40, no retire.
- `wfi`: wfi at pc 0x20 → wfi_stall held. meip=1 with MEIE=1, MIE=0 → resume with no trap. With MIE=1 → mcause=0x8000000B, mepc=0x24.
- `mret`: mepc=0x300, MPIE=1 → trap_address=0x300, MIE=1. Assert reset mid-WAIT → wfi_stall=0 and all CSRs 0.
